csr_commit_stage: RTL and testbench

- Writeback/commit stage that sits directly upstream of the control-state-register unit.
- Accepts one instruction bundle per cycle from the MEM stage over a valid/allowin handshake and resolves exception priority into an ecode/esubcode.
- Drives the CSR unit's inst and hardware interfaces, commits register-file writes, and returns CSR, timer-ID and stable-counter read data.
- Holds a flush state after an exception or ertn until the front end acknowledges the redirect.

---
 rtl/csr_commit_stage_if.sv | 33 +++
 rtl/csr_commit_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_csr_commit_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_commit_stage_if.sv
// MEM -> WB bundle channel: valid/allowin handshake plus the instruction fields
// that the commit stage needs to resolve exceptions and retire the instruction.
interface csr_commit_stage_if;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [5:0]  ms_exc;        // {int, adef, ine, sys, brk, ale}
   logic        ms_ertn;
   logic [31:0] ms_vaddr;
   logic        ms_csr_we;
   logic [13:0] ms_csr_num;
   logic [31:0] ms_csr_wmask;
   logic [31:0] ms_csr_wvalue;
   logic        ms_rf_we;
   logic [4:0]  ms_rf_waddr;
   logic [31:0] ms_rf_wdata;
   logic [2:0]  ms_res_sel;    // one-hot {csr, cnt_id, cnt}
   logic        ms_cnt_hi;

   modport master (
      output ms_to_ws_valid, ms_pc, ms_exc, ms_ertn, ms_vaddr,
             ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
             ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_res_sel, ms_cnt_hi,
      input  ws_allowin
   );

   modport slave (
      input  ms_to_ws_valid, ms_pc, ms_exc, ms_ertn, ms_vaddr,
             ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
             ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_res_sel, ms_cnt_hi,
      output ws_allowin
   );
endinterface

// File: rtl/csr_commit_stage.sv
// Writeback/commit stage in front of the CSR unit. Latches one MEM bundle per
// cycle, commits it the following cycle (exception resolution, CSR write,
// register-file write with CSR/timer-ID/stable-counter read data), and holds a
// redirect request after an exception or ertn until the front end acknowledges.
module csr_commit_stage #(
   parameter int               CNT_W    = 64,
   parameter logic [CNT_W-1:0] CNT_INIT = {CNT_W{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   csr_commit_stage_if.slave   ms_if,
   output logic [13:0]         o_csr_num,
   output logic                o_csr_we,
   output logic [31:0]         o_csr_wmask,
   output logic [31:0]         o_csr_wvalue,
   input  logic [31:0]         i_csr_rvalue,
   input  logic [31:0]         i_wb_tid,
   output logic                o_wb_ex,
   output logic                o_ertn_flush,
   output logic [5:0]          o_wb_ecode,
   output logic [8:0]          o_wb_esubcode,
   output logic [31:0]         o_wb_pc,
   output logic [31:0]         o_wb_vaddr,
   output logic                o_flush_req,
   input  logic                i_flush_ack,
   output logic                o_rf_we,
   output logic [4:0]          o_rf_waddr,
   output logic [31:0]         o_rf_wdata
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Fixed-priority exception encoder: int > adef > ine > sys > brk > ale.
   function automatic logic [5:0] exc_ecode(input logic [5:0] exc);
      logic [5:0] code;
      casez (exc)
         6'b1?????: code = 6'h00;
         6'b01????: code = 6'h08;
         6'b001???: code = 6'h0D;
         6'b0001??: code = 6'h0B;
         6'b00001?: code = 6'h0C;
         6'b000001: code = 6'h09;
         default:   code = 6'h00;
      endcase
      return code;
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ws_valid;
   logic [CNT_W-1:0] r_cnt;

   logic [31:0]      r_pc;
   logic [5:0]       r_exc;
   logic             r_has_exc;
   logic             r_ertn;
   logic [31:0]      r_vaddr;
   logic             r_csr_we;
   logic [13:0]      r_csr_num;
   logic [31:0]      r_csr_wmask;
   logic [31:0]      r_csr_wvalue;
   logic             r_rf_we;
   logic [4:0]       r_rf_waddr;
   logic [31:0]      r_rf_wdata;
   logic [2:0]       r_res_sel;
   logic             r_cnt_hi;

   logic             w_ws_ready_go;
   logic             w_ws_allowin;
   logic             w_load;
   logic             w_ws_valid_nxt;
   logic             w_wb_ex;
   logic             w_ertn_flush;
   logic             w_commit_flush;
   logic [5:0]       w_ecode;
   logic [31:0]      w_rf_wdata;

   // Commit always completes in one cycle, so the stage can always take a bundle.
   assign w_ws_ready_go  = 1'b1;
   assign w_ws_allowin   = ~r_ws_valid | w_ws_ready_go;
   assign w_load         = ms_if.ms_to_ws_valid & w_ws_allowin;

   // A bundle is wrong-path while a redirect is pending or being raised now.
   assign w_wb_ex        = r_ws_valid & r_has_exc;
   assign w_ertn_flush   = r_ws_valid & r_ertn & ~r_has_exc;
   assign w_commit_flush = w_wb_ex | w_ertn_flush;
   assign w_ws_valid_nxt = w_load & (r_state == ST_IDLE) & ~w_commit_flush;

   // Stage-valid register: only right-path bundles become committable.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ws_valid <= 1'b0;
      end else begin
         r_ws_valid <= w_ws_valid_nxt;
      end
   end

   // Bundle registers: capture every accepted bundle; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= 32'h0000_0000;
         r_exc        <= 6'b00_0000;
         r_has_exc    <= 1'b0;
         r_ertn       <= 1'b0;
         r_vaddr      <= 32'h0000_0000;
         r_csr_we     <= 1'b0;
         r_csr_num    <= 14'h0000;
         r_csr_wmask  <= 32'h0000_0000;
         r_csr_wvalue <= 32'h0000_0000;
         r_rf_we      <= 1'b0;
         r_rf_waddr   <= 5'd0;
         r_rf_wdata   <= 32'h0000_0000;
         r_res_sel    <= 3'b000;
         r_cnt_hi     <= 1'b0;
      end else if (w_load) begin
         r_pc         <= ms_if.ms_pc;
         r_exc        <= ms_if.ms_exc;
         r_has_exc    <= |ms_if.ms_exc;
         r_ertn       <= ms_if.ms_ertn;
         r_vaddr      <= ms_if.ms_vaddr;
         r_csr_we     <= ms_if.ms_csr_we;
         r_csr_num    <= ms_if.ms_csr_num;
         r_csr_wmask  <= ms_if.ms_csr_wmask;
         r_csr_wvalue <= ms_if.ms_csr_wvalue;
         r_rf_we      <= ms_if.ms_rf_we;
         r_rf_waddr   <= ms_if.ms_rf_waddr;
         r_rf_wdata   <= ms_if.ms_rf_wdata;
         r_res_sel    <= ms_if.ms_res_sel;
         r_cnt_hi     <= ms_if.ms_cnt_hi;
      end else begin
         r_pc         <= r_pc;
         r_exc        <= r_exc;
         r_has_exc    <= r_has_exc;
         r_ertn       <= r_ertn;
         r_vaddr      <= r_vaddr;
         r_csr_we     <= r_csr_we;
         r_csr_num    <= r_csr_num;
         r_csr_wmask  <= r_csr_wmask;
         r_csr_wvalue <= r_csr_wvalue;
         r_rf_we      <= r_rf_we;
         r_rf_waddr   <= r_rf_waddr;
         r_rf_wdata   <= r_rf_wdata;
         r_res_sel    <= r_res_sel;
         r_cnt_hi     <= r_cnt_hi;
      end
   end

   // Free-running stable counter; wraps naturally at the top of its range.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= CNT_INIT;
      end else begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Redirect FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Redirect FSM next state: enter FLUSH on a committed exception/ertn, leave on ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_commit_flush) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (i_flush_ack) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_FLUSH;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Exception code is only meaningful while an exception is being reported.
   always_comb begin
      w_ecode = 6'h00;
      if (w_wb_ex) begin
         w_ecode = exc_ecode(r_exc);
      end else begin
         w_ecode = 6'h00;
      end
   end

   // Result select for the GPR write: CSR read, timer ID, counter word, or ALU/load data.
   always_comb begin
      w_rf_wdata = r_rf_wdata;
      if (r_res_sel[2]) begin
         w_rf_wdata = i_csr_rvalue;
      end else if (r_res_sel[1]) begin
         w_rf_wdata = i_wb_tid;
      end else if (r_res_sel[0]) begin
         if (r_cnt_hi) begin
            w_rf_wdata = r_cnt[CNT_W-1:CNT_W-32];
         end else begin
            w_rf_wdata = r_cnt[31:0];
         end
      end else begin
         w_rf_wdata = r_rf_wdata;
      end
   end

   assign ms_if.ws_allowin = w_ws_allowin;

   // CSR unit interface: number/mask/value track the bundle (csrrd needs the number too).
   assign o_csr_num     = r_csr_num;
   assign o_csr_wmask   = r_csr_wmask;
   assign o_csr_wvalue  = r_csr_wvalue;
   assign o_csr_we      = r_ws_valid & r_csr_we & ~r_has_exc;

   assign o_wb_ex       = w_wb_ex;
   assign o_ertn_flush  = w_ertn_flush;
   assign o_wb_ecode    = w_ecode;
   assign o_wb_esubcode = 9'h000;
   assign o_wb_pc       = r_pc;
   assign o_wb_vaddr    = r_vaddr;

   assign o_flush_req   = (r_state == ST_FLUSH);

   // An excepting instruction must not update architectural registers.
   assign o_rf_we       = r_ws_valid & r_rf_we & ~r_has_exc;
   assign o_rf_waddr    = r_rf_waddr;
   assign o_rf_wdata    = w_rf_wdata;

endmodule

// File: tb/tb_csr_commit_stage.sv
// Bench for csr_commit_stage: two instances share stimulus; the second starts
// its stable counter just below the wrap point. Table-driven directed vectors,
// hand sequences for flush/reset/counter corners, then random traffic checked
// against a cycle-level reference model.
module tb_csr_commit_stage;

   localparam logic [63:0] WRAP_INIT = 64'hFFFF_FFFF_FFFF_FF80;

   typedef struct packed {
      logic        allowin;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] csr_wmask;
      logic [31:0] csr_wvalue;
      logic        wb_ex;
      logic        ertn_flush;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] wb_pc;
      logic [31:0] wb_vaddr;
      logic        flush_req;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } outs_t;

   typedef struct packed {
      logic [5:0]  exc;
      logic        ertn;
      logic [31:0] pc;
      logic [31:0] vaddr;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [2:0]  sel;
      logic        hi;
   } bund_t;

   typedef struct packed {
      logic [5:0] exc;
      logic       ertn;
      logic       csr_we;
      logic       rf_we;
      logic [5:0] x_ecode;
      logic       x_ex;
      logic       x_ertn;
      logic       x_rf_we;
      logic       x_csr_we;
      logic       x_flush;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        b_valid;
   bund_t       b;
   logic [31:0] csr_rvalue;
   logic [31:0] wb_tid;
   logic        flush_ack;

   int          n_chk = 0;
   int          n_err = 0;

   // reference model state
   logic        m_valid;
   logic        m_flush;
   bund_t       m_b;
   logic [63:0] m_cyc;
   logic [63:0] m_rst_cyc;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      outs_t w_o;
      csr_commit_stage_if u_if ();
      assign u_if.ms_to_ws_valid = b_valid;
      assign u_if.ms_pc          = b.pc;
      assign u_if.ms_exc         = b.exc;
      assign u_if.ms_ertn        = b.ertn;
      assign u_if.ms_vaddr       = b.vaddr;
      assign u_if.ms_csr_we      = b.csr_we;
      assign u_if.ms_csr_num     = b.csr_num;
      assign u_if.ms_csr_wmask   = b.wmask;
      assign u_if.ms_csr_wvalue  = b.wvalue;
      assign u_if.ms_rf_we       = b.rf_we;
      assign u_if.ms_rf_waddr    = b.waddr;
      assign u_if.ms_rf_wdata    = b.wdata;
      assign u_if.ms_res_sel     = b.sel;
      assign u_if.ms_cnt_hi      = b.hi;
      assign w_o.allowin         = u_if.ws_allowin;

      csr_commit_stage #(
         .CNT_W    (64),
         .CNT_INIT ((g == 0) ? 64'd0 : WRAP_INIT)
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .ms_if         (u_if),
         .o_csr_num     (w_o.csr_num),
         .o_csr_we      (w_o.csr_we),
         .o_csr_wmask   (w_o.csr_wmask),
         .o_csr_wvalue  (w_o.csr_wvalue),
         .i_csr_rvalue  (csr_rvalue),
         .i_wb_tid      (wb_tid),
         .o_wb_ex       (w_o.wb_ex),
         .o_ertn_flush  (w_o.ertn_flush),
         .o_wb_ecode    (w_o.ecode),
         .o_wb_esubcode (w_o.esub),
         .o_wb_pc       (w_o.wb_pc),
         .o_wb_vaddr    (w_o.wb_vaddr),
         .o_flush_req   (w_o.flush_req),
         .i_flush_ack   (flush_ack),
         .o_rf_we       (w_o.rf_we),
         .o_rf_waddr    (w_o.rf_waddr),
         .o_rf_wdata    (w_o.rf_wdata)
      );
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // exception priority from the architectural table: int > adef > ine > sys > brk > ale
   function automatic logic [5:0] prio_code(input logic [5:0] exc);
      logic [5:0] codes [6];
      codes = '{6'h09, 6'h0C, 6'h0B, 6'h0D, 6'h08, 6'h00};
      for (int i = 5; i >= 0; i--) begin
         if (exc[i]) return codes[i];
      end
      return 6'h00;
   endfunction

   // advance the reference model by one clock edge using the inputs at that edge
   task automatic model_edge();
      logic redirect;
      logic was_flush;
      m_cyc++;
      if (reset) begin
         m_valid   = 1'b0;
         m_flush   = 1'b0;
         m_rst_cyc = m_cyc;
      end else begin
         redirect  = m_valid && (m_b.exc != 6'd0 || m_b.ertn);
         was_flush = m_flush;
         m_flush   = was_flush ? !flush_ack : redirect;
         m_valid   = b_valid && !was_flush && !redirect;
         if (b_valid) m_b = b;
      end
   endtask

   task automatic check_model(input string tag, input outs_t o, input logic [63:0] init);
      logic        exc_hit;
      logic        clean;
      logic [63:0] cnt;
      logic [31:0] rd;
      exc_hit = m_valid && (m_b.exc != 6'd0);
      clean   = m_valid && (m_b.exc == 6'd0);
      cnt     = init + (m_cyc - m_rst_cyc);
      chk({tag, "_allowin"}, o.allowin, 1'b1);
      chk({tag, "_wb_ex"}, o.wb_ex, exc_hit);
      chk({tag, "_ecode"}, o.ecode, exc_hit ? prio_code(m_b.exc) : 6'h00);
      chk({tag, "_esub"}, o.esub, 9'd0);
      chk({tag, "_ertn"}, o.ertn_flush, clean && m_b.ertn);
      chk({tag, "_csr_we"}, o.csr_we, clean && m_b.csr_we);
      chk({tag, "_rf_we"}, o.rf_we, clean && m_b.rf_we);
      chk({tag, "_flush_req"}, o.flush_req, m_flush);
      if (m_valid) begin
         if (m_b.sel == 3'b100)      rd = csr_rvalue;
         else if (m_b.sel == 3'b010) rd = wb_tid;
         else if (m_b.sel == 3'b001) rd = m_b.hi ? cnt[63:32] : cnt[31:0];
         else                        rd = m_b.wdata;
         chk({tag, "_pc"}, o.wb_pc, m_b.pc);
         chk({tag, "_vaddr"}, o.wb_vaddr, m_b.vaddr);
         chk({tag, "_csr_num"}, o.csr_num, m_b.csr_num);
         chk({tag, "_csr_wmask"}, o.csr_wmask, m_b.wmask);
         chk({tag, "_csr_wvalue"}, o.csr_wvalue, m_b.wvalue);
         chk({tag, "_rf_waddr"}, o.rf_waddr, m_b.waddr);
         chk({tag, "_rf_wdata"}, o.rf_wdata, rd);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model("a", gen_dut[0].w_o, 64'd0);
      check_model("b", gen_dut[1].w_o, WRAP_INIT);
   endtask

   task automatic offer(input logic [5:0] exc, input logic ertn, input logic csr_we,
                        input logic rf_we, input logic [2:0] sel, input logic hi,
                        input logic [31:0] wdata);
      b_valid  = 1'b1;
      b.exc    = exc;
      b.ertn   = ertn;
      b.pc     = 32'h1c00_0100;
      b.vaddr  = 32'h0000_0003;
      b.csr_we = csr_we;
      b.csr_num = 14'h0030;
      b.wmask  = 32'hFFFF_FFFF;
      b.wvalue = 32'hDEAD_BEEF;
      b.rf_we  = rf_we;
      b.waddr  = 5'd5;
      b.wdata  = wdata;
      b.sel    = sel;
      b.hi     = hi;
   endtask

   task automatic idle();
      b_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
   endtask

   vec_t  vt [10];
   outs_t zr;

   initial begin
      // exc ertn csr_we rf_we | ecode ex ertn rf_we csr_we flush
      vt[0] = '{6'b000000, 1'b0, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // add.w
      vt[1] = '{6'b000100, 1'b0, 1'b0, 1'b1, 6'h0B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // syscall
      vt[2] = '{6'b100001, 1'b0, 1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // int+ale
      vt[3] = '{6'b000001, 1'b0, 1'b0, 1'b1, 6'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // ale
      vt[4] = '{6'b000000, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // csrwr
      vt[5] = '{6'b010000, 1'b0, 1'b1, 1'b0, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // csrwr+adef
      vt[6] = '{6'b001000, 1'b0, 1'b0, 1'b1, 6'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // ine
      vt[7] = '{6'b000010, 1'b0, 1'b0, 1'b1, 6'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // brk
      vt[8] = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // ertn
      vt[9] = '{6'b000010, 1'b1, 1'b0, 1'b0, 6'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // ertn+brk

      m_valid = 1'b0; m_flush = 1'b0; m_b = '0; m_cyc = 64'd0; m_rst_cyc = 64'd0;
      b = '0; b_valid = 1'b0; flush_ack = 1'b0; csr_rvalue = 32'd0; wb_tid = 32'd0;
      do_reset();

      // reset state: everything zero except the always-ready allowin
      zr = '0;
      zr.allowin = 1'b1;
      chk("reset_outs_a", gen_dut[0].w_o, zr);
      chk("reset_outs_b", gen_dut[1].w_o, zr);

      // table-driven single bundles from IDLE
      for (int i = 0; i < 10; i++) begin
         offer(vt[i].exc, vt[i].ertn, vt[i].csr_we, vt[i].rf_we, 3'b000, 1'b0, 32'h0000_1234);
         tick();
         idle();
         chk($sformatf("v%0d_wb_ex", i), gen_dut[0].w_o.wb_ex, vt[i].x_ex);
         chk($sformatf("v%0d_ecode", i), gen_dut[0].w_o.ecode, vt[i].x_ecode);
         chk($sformatf("v%0d_esub", i), gen_dut[0].w_o.esub, 9'd0);
         chk($sformatf("v%0d_ertn", i), gen_dut[0].w_o.ertn_flush, vt[i].x_ertn);
         chk($sformatf("v%0d_rf_we", i), gen_dut[0].w_o.rf_we, vt[i].x_rf_we);
         chk($sformatf("v%0d_csr_we", i), gen_dut[0].w_o.csr_we, vt[i].x_csr_we);
         chk($sformatf("v%0d_pc", i), gen_dut[0].w_o.wb_pc, 32'h1c00_0100);
         chk($sformatf("v%0d_vaddr", i), gen_dut[0].w_o.wb_vaddr, 32'h0000_0003);
         chk($sformatf("v%0d_waddr", i), gen_dut[0].w_o.rf_waddr, 5'd5);
         chk($sformatf("v%0d_wdata", i), gen_dut[0].w_o.rf_wdata, 32'h0000_1234);
         chk($sformatf("v%0d_flush_now", i), gen_dut[0].w_o.flush_req, 1'b0);
         tick();
         chk($sformatf("v%0d_flush_next", i), gen_dut[0].w_o.flush_req, vt[i].x_flush);
         chk($sformatf("v%0d_csr_we_once", i), gen_dut[0].w_o.csr_we, 1'b0);
         if (vt[i].x_flush) begin
            flush_ack = 1'b1;
            tick();
            flush_ack = 1'b0;
            chk($sformatf("v%0d_flush_done", i), gen_dut[0].w_o.flush_req, 1'b0);
         end
      end

      // syscall, then wrong-path bundles are dropped until the redirect is acknowledged
      offer(6'b000100, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_0001);
      tick();
      chk("sys_ecode", gen_dut[0].w_o.ecode, 6'h0B);
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_AAAA);
      tick();
      chk("sys_same_cycle_drop", gen_dut[0].w_o.rf_we, 1'b0);
      chk("sys_flush_req", gen_dut[0].w_o.flush_req, 1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("sys_flush_drop", gen_dut[0].w_o.rf_we, 1'b0);
      end
      flush_ack = 1'b1;
      tick();
      flush_ack = 1'b0;
      chk("sys_ack_cycle_drop", gen_dut[0].w_o.rf_we, 1'b0);
      chk("sys_back_idle", gen_dut[0].w_o.flush_req, 1'b0);
      tick();
      chk("sys_resume_we", gen_dut[0].w_o.rf_we, 1'b1);
      chk("sys_resume_data", gen_dut[0].w_o.rf_wdata, 32'h0000_AAAA);
      idle();
      tick();

      // flush_ack while IDLE has no effect
      flush_ack = 1'b1;
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_5555);
      tick();
      idle();
      chk("ack_idle_commit", gen_dut[0].w_o.rf_we, 1'b1);
      tick();
      chk("ack_idle_no_flush", gen_dut[0].w_o.flush_req, 1'b0);
      flush_ack = 1'b0;

      // CSR and timer-ID read data select
      csr_rvalue = 32'h1357_9BDF;
      wb_tid     = 32'h2468_ACE0;
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 32'h0);
      tick();
      chk("csrrd_data", gen_dut[0].w_o.rf_wdata, 32'h1357_9BDF);
      chk("csrrd_num", gen_dut[0].w_o.csr_num, 14'h0030);
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);
      tick();
      idle();
      chk("rdcntid_data", gen_dut[0].w_o.rf_wdata, 32'h2468_ACE0);

      // stable counter: sampled 100 cycles after reset, then across the wrap of instance b
      do_reset();
      while (m_cyc - m_rst_cyc < 64'd99) tick();
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0);
      tick();
      idle();
      chk("cnt100_a", gen_dut[0].w_o.rf_wdata, 32'd100);
      chk("cnt100_b", gen_dut[1].w_o.rf_wdata, 32'hFFFF_FFE4);
      while (m_cyc - m_rst_cyc < 64'd126) tick();
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h0);
      tick();
      chk("cnt_max_hi_b", gen_dut[1].w_o.rf_wdata, 32'hFFFF_FFFF);
      chk("cnt127_hi_a", gen_dut[0].w_o.rf_wdata, 32'd0);
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0);
      tick();
      chk("cnt_wrap_lo_b", gen_dut[1].w_o.rf_wdata, 32'd0);
      chk("cnt128_lo_a", gen_dut[0].w_o.rf_wdata, 32'd128);
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 32'h0);
      tick();
      idle();
      chk("cnt_wrap_hi_b", gen_dut[1].w_o.rf_wdata, 32'd0);
      tick();

      // ertn, then reset while in FLUSH (reset wins over ack and an offered bundle)
      offer(6'b000000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
      tick();
      idle();
      chk("ertn_flush", gen_dut[0].w_o.ertn_flush, 1'b1);
      chk("ertn_no_ex", gen_dut[0].w_o.wb_ex, 1'b0);
      tick();
      chk("ertn_flush_req", gen_dut[0].w_o.flush_req, 1'b1);
      reset     = 1'b1;
      flush_ack = 1'b1;
      offer(6'b000000, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0000_7777);
      tick();
      reset     = 1'b0;
      flush_ack = 1'b0;
      idle();
      chk("rst_mid_flush_req", gen_dut[0].w_o.flush_req, 1'b0);
      chk("rst_mid_flush_we", gen_dut[0].w_o.rf_we, 1'b0);
      tick();
      chk("rst_mid_flush_no_commit", gen_dut[0].w_o.rf_we, 1'b0);

      // random traffic against the model
      for (int n = 0; n < 800; n++) begin
         reset     = ($urandom_range(0, 99) == 0);
         flush_ack = ($urandom_range(0, 2) == 0);
         b_valid   = ($urandom_range(0, 9) < 7);
         b.exc     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         b.ertn    = ($urandom_range(0, 9) == 0);
         b.pc      = $urandom;
         b.vaddr   = $urandom;
         b.csr_we  = 1'($urandom);
         b.csr_num = 14'($urandom);
         b.wmask   = $urandom;
         b.wvalue  = $urandom;
         b.rf_we   = 1'($urandom);
         b.waddr   = 5'($urandom);
         b.wdata   = $urandom;
         case ($urandom_range(0, 3))
            0:       b.sel = 3'b000;
            1:       b.sel = 3'b001;
            2:       b.sel = 3'b010;
            default: b.sel = 3'b100;
         endcase
         b.hi       = 1'($urandom);
         csr_rvalue = $urandom;
         wb_tid     = $urandom;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
